// File: rtl/usart_pkg.sv
// Shared constants and transmit-arbiter state encoding for the usart blocks.
package usart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_LATCH = ST_LATCH,
        S_DRAIN = ST_DRAIN
    } usart_tx_state_e;

endpackage

// File: rtl/usart_sync.sv
// Generic 1-bit multi-flop synchroniser; output resets to 0.
module usart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_r;

    // Shift chain; the last stage is the synchronised output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
        end
    end

    assign dout = sync_r[STAGES-1];

endmodule

// File: rtl/usart_tx_arbiter.sv
// Round-robin, one-byte-at-a-time arbiter sharing a single usart_tx between NUM_REQ sources.
// Define USART_TX_ARBITER_PACKET_LOCK_EN to hold the grant until a requester's req_last byte.
module usart_tx_arbiter
    import usart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      comm_clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_latch,
    input  logic                      tx_ready,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    usart_tx_state_e    state_r;
    usart_tx_state_e    state_n_s;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   rr_ptr_n_s;
    logic [PTR_W-1:0]   win_s;
    logic [PTR_W-1:0]   win_inc_s;
    logic               found_s;
    logic [NUM_REQ-1:0] elig_s;
    logic [NUM_REQ-1:0] grant_n_s;
    logic [BYTE_W-1:0]  tx_data_n_s;
    logic               tx_latch_n_s;
    logic               tx_ready_s;

`ifdef USART_TX_ARBITER_PACKET_LOCK_EN
    logic               lock_r;
    logic               lock_n_s;
    logic [PTR_W-1:0]   lock_w_r;
    logic [PTR_W-1:0]   lock_w_n_s;
    logic [NUM_REQ-1:0] lock_mask_s;
`endif

    usart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_tx_ready_sync (
        .clk   (comm_clock),
        .rst_n (reset_n),
        .din   (tx_ready),
        .dout  (tx_ready_s)
    );

`ifdef USART_TX_ARBITER_PACKET_LOCK_EN
    // While a packet is open only its owner is eligible, even if it drops req_valid.
    always_comb begin
        lock_mask_s           = {NUM_REQ{1'b0}};
        lock_mask_s[lock_w_r] = 1'b1;
        elig_s                = lock_r ? (req_valid & lock_mask_s) : req_valid;
    end
`else
    logic unused_last_s;
    assign unused_last_s = ^req_last;
    assign elig_s        = req_valid;
`endif

    // Round-robin search: first eligible requester at or after rr_ptr_r, wrapping at NUM_REQ.
    always_comb begin
        logic [PTR_W:0]   sum_v;
        logic [PTR_W-1:0] idx_v;
        found_s = 1'b0;
        win_s   = {PTR_W{1'b0}};
        sum_v   = {(PTR_W+1){1'b0}};
        idx_v   = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v   = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
            idx_v   = (sum_v >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum_v - (PTR_W+1)'(NUM_REQ))
                                                     : sum_v[PTR_W-1:0];
            win_s   = (!found_s && elig_s[idx_v]) ? idx_v : win_s;
            found_s = found_s | elig_s[idx_v];
        end
        win_inc_s = (win_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : (win_s + PTR_W'(1'b1));
    end

    // Next-state and next-output logic; req_ready is the only combinational output.
    always_comb begin
        state_n_s    = state_r;
        rr_ptr_n_s   = rr_ptr_r;
        grant_n_s    = grant;
        tx_data_n_s  = tx_data;
        tx_latch_n_s = tx_latch;
        req_ready    = {NUM_REQ{1'b0}};
`ifdef USART_TX_ARBITER_PACKET_LOCK_EN
        lock_n_s     = lock_r;
        lock_w_n_s   = lock_w_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (found_s) begin
                    req_ready[win_s]   = 1'b1;
                    tx_data_n_s        = req_data[int'(win_s)*BYTE_W +: BYTE_W];
                    grant_n_s          = {NUM_REQ{1'b0}};
                    grant_n_s[win_s]   = 1'b1;
                    tx_latch_n_s       = 1'b1;
                    state_n_s          = S_LATCH;
`ifdef USART_TX_ARBITER_PACKET_LOCK_EN
                    // Pointer only moves on when the packet closes.
                    if (req_last[win_s]) begin
                        lock_n_s   = 1'b0;
                        rr_ptr_n_s = win_inc_s;
                    end else begin
                        lock_n_s   = 1'b1;
                        lock_w_n_s = win_s;
                    end
`else
                    rr_ptr_n_s         = win_inc_s;
`endif
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_LATCH: begin
                // tx_ready_s low means the transmitter took the byte; no timeout by design.
                if (!tx_ready_s) begin
                    tx_latch_n_s = 1'b0;
                    state_n_s    = S_DRAIN;
                end else begin
                    tx_latch_n_s = 1'b1;
                end
            end
            S_DRAIN: begin
                tx_latch_n_s = 1'b0;
                if (tx_ready_s) begin
                    state_n_s = S_IDLE;
                end else begin
                    state_n_s = S_DRAIN;
                end
            end
            default: begin
                tx_latch_n_s = 1'b0;
                state_n_s    = S_DRAIN;
            end
        endcase
    end

    // State and registered outputs; reset parks in DRAIN until the transmitter reports idle.
    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= S_DRAIN;
            rr_ptr_r <= {PTR_W{1'b0}};
            grant    <= {NUM_REQ{1'b0}};
            tx_data  <= {BYTE_W{1'b0}};
            tx_latch <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state_r  <= state_n_s;
            rr_ptr_r <= rr_ptr_n_s;
            grant    <= grant_n_s;
            tx_data  <= tx_data_n_s;
            tx_latch <= tx_latch_n_s;
            busy     <= (state_n_s != S_IDLE);
        end
    end

`ifdef USART_TX_ARBITER_PACKET_LOCK_EN
    // Packet lock owner and flag.
    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_r   <= 1'b0;
            lock_w_r <= {PTR_W{1'b0}};
        end else begin
            lock_r   <= lock_n_s;
            lock_w_r <= lock_w_n_s;
        end
    end
`endif

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Directed scoreboard bench for usart_tx_arbiter (NUM_REQ=4, SYNC_STAGES=2).
module tb_usart_tx_arbiter;

    localparam int NUM_REQ = 4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] dat;
    } exp_t;

    logic        comm_clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_latch;
    logic        tx_ready;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [8:0]  src_mem [NUM_REQ][16];
    int          src_rd [NUM_REQ];
    int          src_wr [NUM_REQ];
    logic [3:0]  ready_smp;
    logic        latch_prev;
    int          ready_cnt;
    bit          tx_auto;
    int          tx_busy;

    usart_tx_arbiter #(
        .NUM_REQ     (4),
        .SYNC_STAGES (2)
    ) dut (
        .comm_clock (comm_clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_data    (tx_data),
        .tx_latch   (tx_latch),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    always #5 comm_clock = ~comm_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_src(input int idx, input logic [7:0] dat, input logic last);
        src_mem[idx][src_wr[idx]] = {last, dat};
        src_wr[idx]++;
    endtask

    task automatic push_exp(input logic [3:0] gnt, input logic [7:0] dat);
        exp_t e;
        e.gnt = gnt;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_rd[i] != src_wr[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (!(src_empty() && exp_q.size() == 0 && busy === 1'b0) && n < limit) begin
            @(negedge comm_clock);
            n++;
        end
        chk(tag, {31'd0, (src_empty() && exp_q.size() == 0 && busy === 1'b0)}, 32'd1);
    endtask

    initial begin
        int n;
        reset_n    = 1'b0;
        req_valid  = 4'd0;
        req_data   = 32'd0;
        req_last   = 4'd0;
        tx_ready   = 1'b1;
        tx_auto    = 1'b0;
        tx_busy    = 20;
        ready_smp  = 4'd0;
        latch_prev = 1'b0;
        ready_cnt  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
            for (int j = 0; j < 16; j++) src_mem[i][j] = 9'd0;
        end

        fork
            // requesters: present head byte, advance after an observed req_ready
            forever begin
                @(posedge comm_clock);
                #1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (ready_smp[i] && src_rd[i] != src_wr[i]) src_rd[i]++;
                    req_valid[i]        = (src_rd[i] != src_wr[i]);
                    req_data[i*8 +: 8]  = src_mem[i][src_rd[i]][7:0];
                    req_last[i]         = src_mem[i][src_rd[i]][8];
                end
            end
            // monitor and scoreboard
            begin : mon
                exp_t e;
                forever begin
                    @(negedge comm_clock);
                    ready_smp = req_ready;
                    if (reset_n === 1'b1) begin
                        if (|req_ready) begin
                            ready_cnt++;
                            chk("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
                            chk("ready_only_idle", {31'd0, busy}, 32'd0);
                        end
                        if (tx_latch === 1'b1 && latch_prev === 1'b0) begin
                            if (exp_q.size() == 0) begin
                                chk("byte_expected", 32'(exp_q.size()), 32'd1);
                            end else begin
                                e = exp_q.pop_front();
                                chk("sb_tx_data", {24'd0, tx_data}, {24'd0, e.dat});
                                chk("sb_grant", {28'd0, grant}, {28'd0, e.gnt});
                            end
                        end
                    end
                    latch_prev = tx_latch;
                end
            end
            // transmitter model: accepts on tx_latch, busy for tx_busy cycles
            forever begin
                @(negedge comm_clock);
                if (tx_auto && tx_latch === 1'b1 && tx_ready === 1'b1) begin
                    tx_ready = 1'b0;
                    repeat (tx_busy) @(negedge comm_clock);
                    tx_ready = 1'b1;
                end
            end
        join_none

        // reset then idle
        repeat (3) @(negedge comm_clock);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_latch", {31'd0, tx_latch}, 32'd0);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        reset_n = 1'b1;
        @(negedge comm_clock);
        chk("busy_during_sync", {31'd0, busy}, 32'd1);
        wait_idle("idle_after_reset", 8);
        chk("idle_latch", {31'd0, tx_latch}, 32'd0);
        chk("idle_grant", {28'd0, grant}, 32'd0);

        // single byte, transmitter handshake driven by hand
        push_src(2, 8'h41, 1'b1);
        push_exp(4'b0100, 8'h41);
        @(negedge comm_clock);
        chk("single_ready", {28'd0, req_ready}, 32'h4);
        chk("single_latch_pre", {31'd0, tx_latch}, 32'd0);
        @(negedge comm_clock);
        chk("single_ready_pulse", {28'd0, req_ready}, 32'd0);
        chk("single_latch", {31'd0, tx_latch}, 32'd1);
        chk("single_data", {24'd0, tx_data}, 32'h41);
        chk("single_grant", {28'd0, grant}, 32'h4);
        tx_ready = 1'b0;
        @(negedge comm_clock);
        chk("latch_hold_1", {31'd0, tx_latch}, 32'd1);
        @(negedge comm_clock);
        chk("latch_hold_2", {31'd0, tx_latch}, 32'd1);
        @(negedge comm_clock);
        chk("latch_fall", {31'd0, tx_latch}, 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd1);
        tx_ready = 1'b1;
        wait_idle("idle_after_single", 10);

        // simultaneous 0 and 3 with rr_ptr at 3: 3 first, then wrap to 0
        tx_auto = 1'b1;
        tx_busy = 20;
        push_src(0, 8'hA0, 1'b1);
        push_src(3, 8'hA3, 1'b1);
        push_exp(4'b1000, 8'hA3);
        push_exp(4'b0001, 8'hA0);
        wait_idle("idle_after_wrap", 200);

        // single active requester gets every byte
        push_src(3, 8'h33, 1'b1);
        push_src(3, 8'h34, 1'b1);
        push_exp(4'b1000, 8'h33);
        push_exp(4'b1000, 8'h34);
        wait_idle("idle_after_solo", 200);

        // all four valid: 10,11,12,13,10 with one req_ready per byte
        n = ready_cnt;
        push_src(0, 8'h10, 1'b1);
        push_src(0, 8'h10, 1'b1);
        push_src(1, 8'h11, 1'b1);
        push_src(2, 8'h12, 1'b1);
        push_src(3, 8'h13, 1'b1);
        push_exp(4'b0001, 8'h10);
        push_exp(4'b0010, 8'h11);
        push_exp(4'b0100, 8'h12);
        push_exp(4'b1000, 8'h13);
        push_exp(4'b0001, 8'h10);
        wait_idle("idle_after_rr", 400);
        chk("rr_ready_count", 32'(ready_cnt - n), 32'd5);

        // reset while latching
        tx_auto = 1'b0;
        push_src(1, 8'h55, 1'b1);
        push_exp(4'b0010, 8'h55);
        n = 0;
        while (tx_latch !== 1'b1 && n < 10) begin
            @(negedge comm_clock);
            n++;
        end
        chk("mid_latch_seen", {31'd0, tx_latch}, 32'd1);
        repeat (10) @(negedge comm_clock);
        chk("latch_no_timeout", {31'd0, tx_latch}, 32'd1);
        push_src(2, 8'h66, 1'b1);
        @(negedge comm_clock);
        chk("no_ready_in_latch", {28'd0, req_ready}, 32'd0);
        tx_ready = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("async_rst_latch", {31'd0, tx_latch}, 32'd0);
        chk("async_rst_ready", {28'd0, req_ready}, 32'd0);
        chk("async_rst_grant", {28'd0, grant}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd1);
        @(negedge comm_clock);
        @(negedge comm_clock);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge comm_clock);
            chk("post_rst_grant", {28'd0, grant}, 32'd0);
            chk("post_rst_ready", {28'd0, req_ready}, 32'd0);
        end
        push_exp(4'b0100, 8'h66);
        tx_auto  = 1'b1;
        tx_ready = 1'b1;
        wait_idle("idle_after_mid_reset", 200);

        // move rr_ptr to 1, then a 3-byte packet on 1 against requester 0
        push_src(0, 8'h70, 1'b1);
        push_exp(4'b0001, 8'h70);
        wait_idle("idle_before_packet", 200);
        push_src(1, 8'h81, 1'b0);
        push_src(1, 8'h82, 1'b0);
        push_src(1, 8'h83, 1'b1);
        push_src(0, 8'h90, 1'b1);
        push_src(0, 8'h91, 1'b1);
`ifdef USART_TX_ARBITER_PACKET_LOCK_EN
        push_exp(4'b0010, 8'h81);
        push_exp(4'b0010, 8'h82);
        push_exp(4'b0010, 8'h83);
        push_exp(4'b0001, 8'h90);
        push_exp(4'b0001, 8'h91);
`else
        push_exp(4'b0010, 8'h81);
        push_exp(4'b0001, 8'h90);
        push_exp(4'b0010, 8'h82);
        push_exp(4'b0001, 8'h91);
        push_exp(4'b0010, 8'h83);
`endif
        wait_idle("idle_after_packet", 400);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
